// File: rtl/gmux_ctrl_pkg.sv
// Shared types and constants for the GMUX select/enable sequencer.
package gmux_ctrl_pkg;

  localparam int unsigned NQ = 4;

  // Quadrant bit positions within every 4-bit mask
  localparam int unsigned Q_TL = 3;
  localparam int unsigned Q_TR = 2;
  localparam int unsigned Q_BL = 1;
  localparam int unsigned Q_BR = 0;

  localparam logic SRC_GCLK = 1'b0;
  localparam logic SRC_HSCK = 1'b1;

  typedef logic [NQ-1:0] qmask_t;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    DRAIN,
    SWITCH,
    SETTLE,
    UNGATE,
    DONE
  } state_e;

  typedef struct packed {
    logic   sel;
    qmask_t mask;
  } cmd_t;

  // Quadrants left off are parked in low-power only when requested
  function automatic qmask_t lp_mask(qmask_t mask, logic lp_en);
    return lp_en ? ~mask : '0;
  endfunction

endpackage

// File: rtl/gmux_ctrl_if.sv
// Command and GMUX-control bundle between a requester and gmux_ctrl.
interface gmux_ctrl_if;
  import gmux_ctrl_pkg::*;

  logic   REQ;
  logic   REQ_SEL;
  qmask_t REQ_QEN;
  logic   LP_EN;
  logic   BUSY;
  logic   ACK;
  logic   SSEL;
  qmask_t DEN;
  qmask_t DYNEN;
  qmask_t SEN;
  qmask_t VLP;

  modport master (
    output REQ, REQ_SEL, REQ_QEN, LP_EN,
    input  BUSY, ACK, SSEL, DEN, DYNEN, SEN, VLP
  );

  modport slave (
    input  REQ, REQ_SEL, REQ_QEN, LP_EN,
    output BUSY, ACK, SSEL, DEN, DYNEN, SEN, VLP
  );

endinterface

// File: rtl/gmux_ctrl_timer.sv
// Loadable down-counter shared by the drain and settle waits; saturates at zero.
module gmux_ctrl_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero_c = (value == '0);

endmodule

// File: rtl/gmux_ctrl.sv
// Glitch-safe GMUX source switch: gate all quadrants, drain, flip SSEL,
// settle, then apply the requested quadrant mask and pulse ACK.
module gmux_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4,
  parameter logic        RESET_SSEL    = 1'b0
) (
  input  logic        QCK,
  input  logic        QRT,
  gmux_ctrl_if.slave  bus
);

  localparam int unsigned       CNT_MAX     = (32'd1 << CNT_W) - 32'd1;
  localparam bit                CFG_OK      = (DRAIN_CYCLES  >= 1) && (DRAIN_CYCLES  <= CNT_MAX) &&
                                              (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= CNT_MAX);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e state, next_state;
  cmd_t   cmd_q, cmd_d;
  logic   ssel_q, ssel_d;
  qmask_t den_q, den_d, dynen_q, dynen_d, sen_q, sen_d, vlp_q, vlp_d;
  logic   ack_q, ack_d, busy_q, busy_d;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val, tmr_value;

  gmux_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (QCK),
    .rst      (QRT),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero_c   (tmr_zero)
  );

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, timer control, and the output values for the state being entered
  always_comb begin
    next_state = state;
    cmd_d      = cmd_q;
    ssel_d     = ssel_q;
    den_d      = den_q;
    dynen_d    = dynen_q;
    sen_d      = sen_q;
    vlp_d      = vlp_q;
    ack_d      = 1'b0;
    busy_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.REQ) begin
          cmd_d      = '{sel: bus.REQ_SEL, mask: bus.REQ_QEN};
          next_state = (bus.REQ_SEL != ssel_q) ? GATE : UNGATE;
        end
      end
      GATE: begin
        tmr_load   = 1'b1;
        tmr_val    = DRAIN_LOAD;
        next_state = DRAIN;
      end
      DRAIN: begin
        tmr_dec = 1'b1;
        if (tmr_zero) next_state = SWITCH;
      end
      SWITCH: begin
        tmr_load   = 1'b1;
        tmr_val    = SETTLE_LOAD;
        next_state = SETTLE;
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) next_state = UNGATE;
      end
      UNGATE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // Registered outputs take effect on entry to each state
    unique case (next_state)
      GATE: begin
        den_d   = '0;
        dynen_d = '1;
      end
      SWITCH: ssel_d = cmd_d.sel;
      UNGATE: begin
        sen_d   = cmd_d.mask;
        den_d   = cmd_d.mask;
        dynen_d = '0;
        vlp_d   = lp_mask(cmd_d.mask, bus.LP_EN);
      end
      DONE:    ack_d = 1'b1;
      default: ;
    endcase

    busy_d = (next_state != IDLE) && (next_state != DONE);
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      cmd_q   <= '0;
      ssel_q  <= RESET_SSEL;
      den_q   <= '0;
      dynen_q <= '0;
      sen_q   <= '0;
      vlp_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      ssel_q  <= ssel_d;
      den_q   <= den_d;
      dynen_q <= dynen_d;
      sen_q   <= sen_d;
      vlp_q   <= vlp_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.SSEL  = ssel_q;
  assign bus.DEN   = den_q;
  assign bus.DYNEN = dynen_q;
  assign bus.SEN   = sen_q;
  assign bus.VLP   = vlp_q;
  assign bus.ACK   = ack_q;
  assign bus.BUSY  = busy_q;

  // Configuration range, idle timer drained, and SSEL only moves with every quadrant gated
  always_ff @(posedge QCK) begin
    if (!QRT) begin
      assert (CFG_OK)
        else $error("gmux_ctrl: DRAIN_CYCLES/SETTLE_CYCLES outside 1..2^CNT_W-1");
      assert ((state != IDLE) || (tmr_value == '0))
        else $error("gmux_ctrl: timer not drained in IDLE");
      assert ((ssel_d == ssel_q) || ((den_q == '0) && (den_d == '0)))
        else $error("gmux_ctrl: SSEL change with a quadrant enabled");
    end
  end

endmodule

// File: tb/tb_gmux_ctrl.sv
// Randomized and directed checks of gmux_ctrl against a request-timeline model.
module tb_gmux_ctrl;
  import gmux_ctrl_pkg::*;

  localparam int   D       = 4;
  localparam int   S       = 4;
  localparam logic RST_SEL = SRC_GCLK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gmux_ctrl_if bus ();

  gmux_ctrl #(
    .DRAIN_CYCLES  (D),
    .SETTLE_CYCLES (S),
    .CNT_W         (4),
    .RESET_SSEL    (RST_SEL)
  ) dut (
    .QCK (clk),
    .QRT (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int model_dones = 0;

  // Model: committed outputs plus position within the current request timeline
  logic       m_ssel, m_sel, m_chg, m_active;
  logic [3:0] m_den, m_dynen, m_sen, m_vlp, m_mask;
  int         m_t, m_len;

  logic       prev_ssel;
  logic [3:0] prev_den;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ssel = RST_SEL; m_den = '0; m_dynen = '0; m_sen = '0; m_vlp = '0;
    m_active = 1'b0; m_t = 0; m_len = 0; m_chg = 1'b0; m_sel = 1'b0; m_mask = '0;
  endfunction

  // One clock edge of the request timeline: accept, advance, apply milestones
  function automatic void model_edge(input logic req, input logic sel,
                                     input logic [3:0] mask, input logic lp);
    if (m_active) begin
      m_t++;
      if (m_t > m_len) m_active = 1'b0;
    end else if (req) begin
      m_active = 1'b1;
      m_t      = 1;
      m_sel    = sel;
      m_mask   = mask;
      m_chg    = (sel != m_ssel);
      m_len    = m_chg ? (D + S + 4) : 2;
    end
    if (m_active) begin
      if (m_chg && m_t == 1) begin m_den = '0; m_dynen = '1; end
      if (m_chg && m_t == D + 2) m_ssel = m_sel;
      if (m_t == m_len - 1) begin
        m_den = m_mask; m_sen = m_mask; m_dynen = '0;
        m_vlp = lp ? ~m_mask : 4'h0;
      end
      if (m_t == m_len) model_dones++;
    end
  endfunction

  task automatic compare_all();
    check("ssel",  32'(bus.SSEL),  32'(m_ssel));
    check("den",   32'(bus.DEN),   32'(m_den));
    check("dynen", 32'(bus.DYNEN), 32'(m_dynen));
    check("sen",   32'(bus.SEN),   32'(m_sen));
    check("vlp",   32'(bus.VLP),   32'(m_vlp));
    check("busy",  32'(bus.BUSY),  32'(m_active && (m_t < m_len)));
    check("ack",   32'(bus.ACK),   32'(m_active && (m_t == m_len)));
    if (bus.ACK === 1'b1) ack_cnt++;
  endtask

  task automatic step();
    logic r, s, l;
    logic [3:0] q;
    r = bus.REQ; s = bus.REQ_SEL; q = bus.REQ_QEN; l = bus.LP_EN;
    @(posedge clk);
    model_edge(r, s, q, l);
    @(negedge clk);
    compare_all();
    if (bus.SSEL !== prev_ssel) begin
      check("glitch_den_before", 32'(prev_den), 32'(0));
      check("glitch_den_after",  32'(bus.DEN),  32'(0));
    end
    prev_ssel = bus.SSEL;
    prev_den  = bus.DEN;
  endtask

  // One-cycle REQ strobe, then wait (bounded) for ACK; lat = edges from accept to DONE
  task automatic issue(input logic sel, input logic [3:0] mask, input logic lp, output int lat);
    bus.REQ = 1'b1; bus.REQ_SEL = sel; bus.REQ_QEN = mask; bus.LP_EN = lp;
    step();
    bus.REQ = 1'b0;
    lat = 1;
    while (bus.ACK !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat, a0, d0, guard, acc, budget;
    bus.REQ = 1'b0; bus.REQ_SEL = 1'b0; bus.REQ_QEN = 4'h0; bus.LP_EN = 1'b0;
    model_reset();
    prev_ssel = RST_SEL;
    prev_den  = '0;

    // Reset values
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    step();

    // Source change GCLKIN -> GHSCK, all quadrants
    issue(SRC_HSCK, 4'hF, 1'b0, lat);
    check("lat_chg", 32'(lat), 32'(D + S + 4));
    step();
    check("ack_single", 32'(bus.ACK), 32'(0));

    // Mask-only update with low-power parking
    issue(SRC_HSCK, 4'b1010, 1'b1, lat);
    check("lat_mask", 32'(lat), 32'(2));
    check("mask_den", 32'(bus.DEN), 32'(4'b1010));
    check("mask_vlp", 32'(bus.VLP), 32'(4'b0101));
    step();

    issue(SRC_GCLK, 4'hF, 1'b0, lat);
    step();

    // Second request during DRAIN must be ignored
    a0 = ack_cnt;
    bus.REQ = 1'b1; bus.REQ_SEL = SRC_HSCK; bus.REQ_QEN = 4'b0110;
    step();
    bus.REQ = 1'b0;
    step(); step();
    bus.REQ = 1'b1; bus.REQ_SEL = SRC_GCLK; bus.REQ_QEN = 4'b1001;
    step(); step(); step();
    bus.REQ = 1'b0;
    for (int i = 0; i < D + S + 6; i++) step();
    check("busy_req_ssel", 32'(bus.SSEL), 32'(SRC_HSCK));
    check("busy_req_acks", 32'(ack_cnt - a0), 32'(1));
    check("busy_req_den",  32'(bus.DEN),  32'(4'b0110));

    // Source change with empty mask ends fully gated
    issue(SRC_GCLK, 4'h0, 1'b1, lat);
    check("mask0_den", 32'(bus.DEN), 32'(0));
    check("mask0_vlp", 32'(bus.VLP), 32'(4'hF));
    step();

    // Asynchronous reset in the middle of SETTLE
    bus.REQ = 1'b1; bus.REQ_SEL = SRC_HSCK; bus.REQ_QEN = 4'b0011; bus.LP_EN = 1'b1;
    step();
    bus.REQ = 1'b0;
    guard = 0;
    while (m_t != D + 3 && guard < 50) begin step(); guard++; end
    check("reach_settle", 32'(m_t), 32'(D + 3));
    a0 = ack_cnt;
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    prev_ssel = bus.SSEL;
    prev_den  = bus.DEN;
    #1 rst = 1'b0;
    for (int i = 0; i < D + S + 6; i++) step();
    check("rst_no_ack", 32'(ack_cnt - a0), 32'(0));
    issue(SRC_HSCK, 4'hF, 1'b1, lat);
    check("lat_after_rst", 32'(lat), 32'(D + S + 4));
    step();

    // Random request stream; inputs churn freely while a request is in flight
    acc = 0; budget = 0;
    a0 = ack_cnt; d0 = model_dones;
    while (acc < 1000 && budget < 60000) begin
      if (!m_active) bus.LP_EN = 1'($urandom_range(0, 1));
      bus.REQ     = ($urandom_range(0, 2) == 0);
      bus.REQ_SEL = 1'($urandom_range(0, 1));
      bus.REQ_QEN = 4'($urandom_range(0, 15));
      step();
      if (m_active && m_t == 1) acc++;
      budget++;
    end
    bus.REQ = 1'b0;
    for (int i = 0; i < D + S + 6; i++) step();
    check("rand_accepted", 32'(acc), 32'(1000));
    check("rand_acks", 32'(ack_cnt - a0), 32'(model_dones - d0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
